instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 229 ++++++++++++++++++++++
 tb/tb_instr_fetch.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch front end. Issues one word-aligned request at
//            a time to instruction memory, buffers returned words in a
//            2-entry FIFO and presents them to the decoder with their PC.
//            A redirect pulse flushes the FIFO, discards any response still
//            in flight and restarts fetch at the new address.
//
// Ports    : clk             - single clock, rising edge
//            boot            - asynchronous active-low reset
//            imem_req_valid  - fetch request valid (decoded from state reg)
//            imem_req_ready  - memory accepts the request
//            imem_req_addr   - fetch address, word aligned
//            imem_rsp_valid  - response data valid
//            imem_rsp_data   - fetched instruction word
//            redirect        - one-cycle pulse: flush and refetch
//            redirect_pc     - new fetch address, sampled with redirect
//            ir_valid        - instruction available to decoder
//            ir_ready        - decoder consumes instruction
//            ir              - instruction word
//            ir_pc           - address of ir
//            stall_cnt       - decoder starvation counter
//
// Macro    : FETCH_STALL_CNT_EN - when defined, stall_cnt counts cycles in
//            which the decoder is ready but no instruction is available
//            (saturating). When undefined, stall_cnt is tied to zero.
//
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] BOOT_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        boot,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0]  c_st_idle   = 2'd0;
  localparam logic [1:0]  c_st_req    = 2'd1;
  localparam logic [1:0]  c_st_wait   = 2'd2;
  localparam logic [1:0]  c_st_drop   = 2'd3;
  localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;
  localparam logic [31:0] c_boot_pc   = BOOT_PC & c_word_mask;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        r_started;     // set on the first edge after reset release
  logic [31:0] r_fetch_pc;    // address of the next request
  logic [31:0] r_pend_addr;   // address of the request in flight

  logic        r_head_valid;
  logic [31:0] r_head_data;
  logic [31:0] r_head_pc;
  logic        r_tail_valid;
  logic [31:0] r_tail_data;
  logic [31:0] r_tail_pc;

  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_occ;
  logic [1:0]  w_occ_next;
  logic [31:0] w_redirect_pc;

  assign w_redirect_pc = redirect_pc & c_word_mask;
  assign w_accept      = (r_state == c_st_req) && imem_req_ready;
  // Redirect wins over everything: no push, no pop on that edge.
  assign w_push        = (r_state == c_st_wait) && imem_rsp_valid && !redirect;
  assign w_pop         = r_head_valid && ir_ready && !redirect;
  assign w_occ         = {1'b0, r_head_valid} + {1'b0, r_tail_valid};
  assign w_occ_next    = w_occ + {1'b0, w_push} - {1'b0, w_pop};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge boot) begin
    if (!boot) begin
      r_state   <= c_st_idle;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_started <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (redirect) begin
          w_state_next = c_st_req;
        end else if (r_started && (w_occ < 2'd2)) begin
          w_state_next = c_st_req;
        end
      end
      c_st_req: begin
        // Redirect without a handshake just retargets the pending request.
        if (w_accept) begin
          w_state_next = redirect ? c_st_drop : c_st_wait;
        end
      end
      c_st_wait: begin
        if (redirect) begin
          // A response landing with the redirect is the only one in flight,
          // so it is dropped right here and nothing is left to discard.
          w_state_next = imem_rsp_valid ? c_st_req : c_st_drop;
        end else if (imem_rsp_valid) begin
          w_state_next = (w_occ_next < 2'd2) ? c_st_req : c_st_idle;
        end
      end
      c_st_drop: begin
        if (imem_rsp_valid) begin
          w_state_next = c_st_req;
        end
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (all from registers)
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req_valid = (r_state == c_st_req);
    imem_req_addr  = r_fetch_pc;
    ir_valid       = r_head_valid;
    ir             = r_head_data;
    ir_pc          = r_head_pc;
  end

  // --------------------------------------------------------------------------
  // Fetch address
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge boot) begin
    if (!boot) begin
      r_fetch_pc  <= c_boot_pc;
      r_pend_addr <= c_boot_pc;
    end else begin
      if (redirect) begin
        r_fetch_pc <= w_redirect_pc;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;  // wraps naturally at 2^32
      end
      if (w_accept) begin
        r_pend_addr <= r_fetch_pc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // 2-entry FIFO: the head register drives the decoder directly, so a word
  // pushed into an empty FIFO is visible on the next cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge boot) begin
    if (!boot) begin
      r_head_valid <= 1'b0;
      r_head_data  <= 32'h0;
      r_head_pc    <= 32'h0;
      r_tail_valid <= 1'b0;
      r_tail_data  <= 32'h0;
      r_tail_pc    <= 32'h0;
    end else if (redirect) begin
      r_head_valid <= 1'b0;
      r_tail_valid <= 1'b0;
    end else if (w_pop) begin
      if (r_tail_valid) begin
        r_head_data  <= r_tail_data;
        r_head_pc    <= r_tail_pc;
        r_tail_valid <= w_push;
        if (w_push) begin
          r_tail_data <= imem_rsp_data;
          r_tail_pc   <= r_pend_addr;
        end
      end else begin
        r_head_valid <= w_push;
        if (w_push) begin
          r_head_data <= imem_rsp_data;
          r_head_pc   <= r_pend_addr;
        end
      end
    end else if (w_push) begin
      if (!r_head_valid) begin
        r_head_valid <= 1'b1;
        r_head_data  <= imem_rsp_data;
        r_head_pc    <= r_pend_addr;
      end else begin
        r_tail_valid <= 1'b1;
        r_tail_data  <= imem_rsp_data;
        r_tail_pc    <= r_pend_addr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Decoder starvation counter
  // --------------------------------------------------------------------------
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge boot) begin
    if (!boot) begin
      r_stall_cnt <= 32'h0;
    end else if (ir_ready && !r_head_valid && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch. A cycle table covers boot,
//            steady fetch and a redirect during WAIT; directed sequences cover
//            back-pressure, stall counting, async reset mid-transaction and
//            address wrap; a random phase checks the delivered instruction
//            stream against a sequential-PC reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        clk;
  logic        boot;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] stall_cnt;

  instr_fetch #(.BOOT_PC(BOOT)) dut (
    .clk            (clk),
    .boot           (boot),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ------------------------------------------------------------------------
  // Environment and reference model state
  // ------------------------------------------------------------------------
  int          rdy_pct, ird_pct, rdr_pct, spur_pct;
  int          lat_min, lat_max;
  bit          mem_en;
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_wait;
  logic [31:0] exp_pc;      // PC the decoder must receive next
  logic [31:0] exp_stall;
  logic [31:0] hs_q[$];     // accepted request addresses
  logic [31:0] cons_q[$];   // consumed instruction PCs
  bit          p_rdr, p_irv, p_ird, p_qv, p_qr;
  logic [31:0] p_ir, p_irpc, p_qa;

  task automatic clear_model();
    mem_busy  = 1'b0;
    mem_wait  = 0;
    exp_pc    = BOOT;
    exp_stall = 32'h0;
    hs_q.delete();
    cons_q.delete();
    p_rdr = 0; p_irv = 0; p_ird = 0; p_qv = 0; p_qr = 0;
    p_ir = 0; p_irpc = 0; p_qa = 0;
  endtask

  task automatic drive_inputs();
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    ir_ready       = ($urandom_range(99) < ird_pct);
    redirect       = ($urandom_range(99) < rdr_pct);
    redirect_pc    = $urandom;
    if (mem_busy) begin
      if (mem_en && mem_wait <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_wait > 1) mem_wait--;
      end
    end else begin
      // Nothing outstanding: any response now is stray and must be ignored.
      imem_rsp_valid = ($urandom_range(99) < spur_pct);
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, " req_valid"}, imem_req_valid, 0);
    check({tag, " req_addr"},  imem_req_addr,  BOOT);
    check({tag, " ir_valid"},  ir_valid,       0);
    check({tag, " ir"},        ir,             0);
    check({tag, " ir_pc"},     ir_pc,          0);
    check({tag, " stall_cnt"}, stall_cnt,      0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    boot = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect = 0; redirect_pc = 0; ir_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    clear_model();
    boot = 1'b1;
    drive_inputs();
  endtask

  // One clock: observe at the falling edge, then drive after the rising edge.
  task automatic tick();
    bit hs;
    @(negedge clk);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt", stall_cnt, exp_stall);
`else
    check("stall_cnt", stall_cnt, 32'h0);
`endif
    if (ir_ready && !ir_valid && exp_stall != 32'hFFFF_FFFF) exp_stall++;

    if (p_rdr) begin
      check("flush ir_valid", ir_valid, 0);
    end else if (p_irv && !p_ird) begin
      check("hold ir_valid", ir_valid, 1);
      check("hold ir", ir, p_ir);
      check("hold ir_pc", ir_pc, p_irpc);
    end
    if (p_qv && !p_qr && !p_rdr) begin
      check("req hold valid", imem_req_valid, 1);
      check("req hold addr", imem_req_addr, p_qa);
    end

    if (redirect) begin
      exp_pc = redirect_pc & 32'hFFFF_FFFC;
    end else if (ir_valid && ir_ready) begin
      check("stream ir_pc", ir_pc, exp_pc);
      check("stream ir", ir, mem_word(exp_pc));
      cons_q.push_back(ir_pc);
      exp_pc = exp_pc + 32'd4;
    end

    hs = imem_req_valid && imem_req_ready;
    if (hs) check("one outstanding", mem_busy, 0);
    if (imem_rsp_valid && mem_busy) mem_busy = 1'b0;
    if (hs) begin
      hs_q.push_back(imem_req_addr);
      mem_busy = 1'b1;
      mem_addr = imem_req_addr;
      mem_wait = $urandom_range(lat_max, lat_min);
    end

    p_rdr = redirect; p_irv = ir_valid; p_ird = ir_ready;
    p_ir = ir; p_irpc = ir_pc;
    p_qv = imem_req_valid; p_qr = imem_req_ready; p_qa = imem_req_addr;

    @(posedge clk); #1;
    drive_inputs();
  endtask

  // ------------------------------------------------------------------------
  // Cycle table: inputs for one cycle and the outputs expected in it
  // ------------------------------------------------------------------------
  typedef struct {
    logic        rr, rv;
    logic [31:0] rd;
    logic        ird, rdr;
    logic [31:0] rpc;
    logic        qv;
    logic [31:0] qa;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                              input logic ird, input logic rdr, input logic [31:0] rpc,
                              input logic qv, input logic [31:0] qa,
                              input logic iv, input logic [31:0] ipc);
    vec_t v;
    v.rr = rr; v.rv = rv; v.rd = rd; v.ird = ird; v.rdr = rdr; v.rpc = rpc;
    v.qv = qv; v.qa = qa; v.iv = iv; v.ipc = ipc;
    return v;
  endfunction

  initial begin
    int n;

    tbl[0]  = mk(1, 0, 0,                     1, 0, 0,          0, 32'h100,  0, 0);
    tbl[1]  = mk(1, 0, 0,                     1, 0, 0,          0, 32'h100,  0, 0);
    tbl[2]  = mk(1, 0, 0,                     1, 0, 0,          1, 32'h100,  0, 0);
    tbl[3]  = mk(1, 1, mem_word(32'h100),     1, 0, 0,          0, 32'h104,  0, 0);
    tbl[4]  = mk(1, 0, 0,                     1, 0, 0,          1, 32'h104,  1, 32'h100);
    tbl[5]  = mk(1, 1, mem_word(32'h104),     1, 0, 0,          0, 32'h108,  0, 0);
    tbl[6]  = mk(1, 0, 0,                     1, 0, 0,          1, 32'h108,  1, 32'h104);
    tbl[7]  = mk(1, 1, mem_word(32'h108),     1, 0, 0,          0, 32'h10C,  0, 0);
    tbl[8]  = mk(1, 0, 0,                     0, 0, 0,          1, 32'h10C,  1, 32'h108);
    tbl[9]  = mk(1, 0, 0,                     0, 1, 32'h2003,   0, 32'h110,  1, 32'h108);
    tbl[10] = mk(1, 1, mem_word(32'h10C),     1, 0, 0,          0, 32'h2000, 0, 0);
    tbl[11] = mk(1, 0, 0,                     1, 0, 0,          1, 32'h2000, 0, 0);
    tbl[12] = mk(1, 1, mem_word(32'h2000),    1, 0, 0,          0, 32'h2004, 0, 0);
    tbl[13] = mk(0, 0, 0,                     1, 0, 0,          1, 32'h2004, 1, 32'h2000);
    tbl[14] = mk(0, 0, 0,                     1, 0, 0,          1, 32'h2004, 0, 0);

    // ---------------- power-on reset and cycle table ----------------
    boot = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect = 0; redirect_pc = 0; ir_ready = 0;
    rdy_pct = 0; ird_pct = 0; rdr_pct = 0; spur_pct = 0;
    lat_min = 1; lat_max = 1; mem_en = 1;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1;
    boot = 1'b1;
    for (int i = 0; i < 15; i++) begin
      imem_req_ready = tbl[i].rr;
      imem_rsp_valid = tbl[i].rv;
      imem_rsp_data  = tbl[i].rd;
      ir_ready       = tbl[i].ird;
      redirect       = tbl[i].rdr;
      redirect_pc    = tbl[i].rpc;
      @(negedge clk);
      check($sformatf("tbl%0d req_valid", i), imem_req_valid, tbl[i].qv);
      check($sformatf("tbl%0d req_addr", i),  imem_req_addr,  tbl[i].qa);
      check($sformatf("tbl%0d ir_valid", i),  ir_valid,       tbl[i].iv);
      if (tbl[i].iv) begin
        check($sformatf("tbl%0d ir_pc", i), ir_pc, tbl[i].ipc);
        check($sformatf("tbl%0d ir", i),    ir,    mem_word(tbl[i].ipc));
      end
      @(posedge clk); #1;
    end

    // ---------------- decoder blocked: FIFO fills, fetch stops ----------------
    rdy_pct = 100; ird_pct = 0; rdr_pct = 0; spur_pct = 0;
    lat_min = 1; lat_max = 1; mem_en = 1;
    do_reset();
    repeat (20) tick();
    check("full req count", hs_q.size(), 2);
    if (hs_q.size() >= 2) begin
      check("full req0 addr", hs_q[0], BOOT);
      check("full req1 addr", hs_q[1], BOOT + 32'd4);
    end
    check("full req_valid", imem_req_valid, 0);
    check("full ir_valid", ir_valid, 1);
    check("full ir_pc", ir_pc, BOOT);
    check("full ir", ir, mem_word(BOOT));

    // ---------------- memory silent: first request timing and stall count ----
    rdy_pct = 100; ird_pct = 100; mem_en = 0;
    do_reset();
    n = 0;
    while (hs_q.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    check("first req edge", n, 3);
    repeat (10) begin
      tick();
      n++;
    end
`ifdef FETCH_STALL_CNT_EN
    check("stall total", stall_cnt, n);
`else
    check("stall total", stall_cnt, 32'h0);
`endif

    // ---------------- async reset during WAIT, late response ignored ----------
    rdy_pct = 100; ird_pct = 0; mem_en = 1; lat_min = 3; lat_max = 3;
    do_reset();
    n = 0;
    while (hs_q.size() < 2 && n < 40) begin
      tick();
      n++;
    end
    check("pre-reset second req", hs_q.size(), 2);
    check("pre-reset ir_valid", ir_valid, 1);
    #2;
    boot = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk_reset_vals("async");
    @(posedge clk); #1;
    clear_model();
    spur_pct = 100; ird_pct = 100; lat_min = 1; lat_max = 1;
    boot = 1'b1;
    drive_inputs();
    tick();
    spur_pct = 0;
    tick();
    check("late rsp ir_valid", ir_valid, 0);
    check("late rsp no req yet", hs_q.size(), 0);
    tick();
    check("restart req count", hs_q.size(), 1);
    if (hs_q.size() >= 1) check("restart req addr", hs_q[0], BOOT);
    n = 0;
    while (cons_q.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    check("restart consumed", cons_q.size(), 1);
    if (cons_q.size() >= 1) check("restart first pc", cons_q[0], BOOT);

    // ---------------- redirect near top of address space: wrap ----------------
    rdy_pct = 100; ird_pct = 100; rdr_pct = 0; spur_pct = 0;
    lat_min = 1; lat_max = 1; mem_en = 1;
    do_reset();
    repeat (6) tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFA;
    cons_q.delete();
    n = 0;
    tick();
    while (cons_q.size() < 4 && n < 40) begin
      tick();
      n++;
    end
    check("wrap consumed", cons_q.size(), 4);
    if (cons_q.size() >= 4) begin
      check("wrap pc0", cons_q[0], 32'hFFFF_FFF8);
      check("wrap pc1", cons_q[1], 32'hFFFF_FFFC);
      check("wrap pc2", cons_q[2], 32'h0000_0000);
      check("wrap pc3", cons_q[3], 32'h0000_0004);
    end

    // ---------------- random traffic against the stream model ----------------
    rdy_pct = 70; ird_pct = 60; rdr_pct = 3; spur_pct = 20;
    lat_min = 1; lat_max = 3; mem_en = 1;
    do_reset();
    repeat (3000) tick();
    check("random progress", (cons_q.size() >= 200) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
